// File: rtl/midi_note_parser.sv
// MIDI channel-voice parser: drives a monophonic {note, velocity} word with last-note priority.
// Define MIDI_CHANNEL_FILTER_EN to accept note messages only on CHANNEL; otherwise omni mode.
module midi_note_parser #(
  parameter int CHANNEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] data_out,
  output logic        note_on,
  output logic        note_off,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2,
    SKIP = 2'd3
  } state_t;

  localparam logic [3:0] CHAN = CHANNEL[3:0];
`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  state_t     state;
  logic       run_on;   // running status is Note On (9n) rather than Note Off (8n)
  logic [7:0] note;

  logic is_realtime;
  logic is_status;
  logic is_note_status;
  logic chan_ok;
  logic release_hit;

  always_comb begin
    is_realtime    = 1'b0;
    is_status      = 1'b0;
    is_note_status = 1'b0;
    chan_ok        = 1'b0;
    release_hit    = 1'b0;
    is_realtime    = (byte_in >= 8'hF8);
    is_status      = byte_in[7] && !is_realtime;
    is_note_status = (byte_in[7:5] == 3'b100);
    chan_ok        = !FILTER || (byte_in[3:0] == CHAN);
    release_hit    = (data_out[15:8] == note) && (data_out != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run_on   <= 1'b0;
      note     <= '0;
      data_out <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      error    <= 1'b0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      error    <= 1'b0;
      if (byte_valid && !is_realtime) begin
        if (is_status) begin
          // Any status aborts a partial message and takes effect at once.
          if (is_note_status && chan_ok) begin
            run_on <= byte_in[4];
            state  <= D1;
          end else begin
            run_on <= 1'b0;
            state  <= SKIP;
          end
        end else begin
          case (state)
            IDLE: error <= 1'b1;
            SKIP: ;
            D1: begin
              note  <= byte_in;
              state <= D2;
            end
            D2: begin
              state <= D1;
              if (run_on && (byte_in != '0)) begin
                data_out <= {note, byte_in};
                note_on  <= 1'b1;
              end else if (release_hit) begin
                data_out <= '0;
                note_off <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser with a queue scoreboard of expected outputs.
module tb_midi_note_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h55;
  logic        byte_valid = 1'b0;
  logic [15:0] data_out;
  logic        note_on, note_off, error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        on;
    logic        off;
    logic        err;
  } exp_t;
  exp_t sb[$];

  midi_note_parser #(.CHANNEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .data_out(data_out), .note_on(note_on), .note_off(note_off), .error(error)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [18:0] obs, input logic [18:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed data=%h on=%b off=%b err=%b, expected data=%h on=%b off=%b err=%b",
             tag, obs[18:3], obs[2], obs[1], obs[0], expv[18:3], expv[2], expv[1], expv[0]);
    end
  endtask

  task automatic check_top();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, {data_out, note_on, note_off, error}, {e.data, e.on, e.off, e.err});
    end
  endtask

  // One byte, then one idle cycle (junk on byte_in) where strobes must drop and data hold.
  task automatic send(input string grp, input logic [7:0] b, input logic [15:0] d,
                      input logic on, input logic off, input logic err);
    exp_t e;
    e.tag = $sformatf("%s_%02h", grp, b);
    e.data = d; e.on = on; e.off = off; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in = 8'h55;
    check_top();
    @(posedge clk);
    #1;
    cmp({e.tag, "_hold"}, {data_out, note_on, note_off, error}, {d, 3'b000});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp(tag, {data_out, note_on, note_off, error}, {16'h0000, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset("reset");

    // Basic note on / note off
    send("basic", 8'h90, 16'h0000, 0, 0, 0);
    send("basic", 8'h3F, 16'h0000, 0, 0, 0);
    send("basic", 8'h64, 16'h3F64, 1, 0, 0);
    send("basic", 8'h80, 16'h3F64, 0, 0, 0);
    send("basic", 8'h3F, 16'h3F64, 0, 0, 0);
    send("basic", 8'h00, 16'h0000, 0, 1, 0);

    // Running status, velocity-0 release
    send("run", 8'h90, 16'h0000, 0, 0, 0);
    send("run", 8'h3C, 16'h0000, 0, 0, 0);
    send("run", 8'h40, 16'h3C40, 1, 0, 0);
    send("run", 8'h3C, 16'h3C40, 0, 0, 0);
    send("run", 8'h00, 16'h0000, 0, 1, 0);
    send("run", 8'h3E, 16'h0000, 0, 0, 0);
    send("run", 8'h7F, 16'h3E7F, 1, 0, 0);
    send("run", 8'h3E, 16'h3E7F, 0, 0, 0);
    send("run", 8'h00, 16'h0000, 0, 1, 0);

    // Last-note priority
    send("prio", 8'h90, 16'h0000, 0, 0, 0);
    send("prio", 8'h3C, 16'h0000, 0, 0, 0);
    send("prio", 8'h40, 16'h3C40, 1, 0, 0);
    send("prio", 8'h3E, 16'h3C40, 0, 0, 0);
    send("prio", 8'h50, 16'h3E50, 1, 0, 0);
    send("prio", 8'h3C, 16'h3E50, 0, 0, 0);
    send("prio", 8'h00, 16'h3E50, 0, 0, 0);
    send("prio", 8'h3E, 16'h3E50, 0, 0, 0);
    send("prio", 8'h00, 16'h0000, 0, 1, 0);

    // Realtime interleave, then abort by control change
    send("rt", 8'h90, 16'h0000, 0, 0, 0);
    send("rt", 8'hF8, 16'h0000, 0, 0, 0);
    send("rt", 8'h3F, 16'h0000, 0, 0, 0);
    send("rt", 8'hFE, 16'h0000, 0, 0, 0);
    send("rt", 8'h64, 16'h3F64, 1, 0, 0);
    send("abort", 8'h90, 16'h3F64, 0, 0, 0);
    send("abort", 8'h3F, 16'h3F64, 0, 0, 0);
    send("abort", 8'hB0, 16'h3F64, 0, 0, 0);
    send("abort", 8'h07, 16'h3F64, 0, 0, 0);
    send("abort", 8'h64, 16'h3F64, 0, 0, 0);
    // Note Off with non-zero release velocity still releases
    send("off", 8'h80, 16'h3F64, 0, 0, 0);
    send("off", 8'h3F, 16'h3F64, 0, 0, 0);
    send("off", 8'h40, 16'h0000, 0, 1, 0);

    // Note 0 is a legal note
    send("n0", 8'h90, 16'h0000, 0, 0, 0);
    send("n0", 8'h00, 16'h0000, 0, 0, 0);
    send("n0", 8'h05, 16'h0005, 1, 0, 0);
    send("n0", 8'h00, 16'h0005, 0, 0, 0);
    send("n0", 8'h00, 16'h0000, 0, 1, 0);

    // Error from IDLE, then SysEx ignored
    do_reset("reset2");
    send("err", 8'h3F, 16'h0000, 0, 0, 1);
    send("sysex", 8'hF0, 16'h0000, 0, 0, 0);
    send("sysex", 8'h3F, 16'h0000, 0, 0, 0);
    send("sysex", 8'h64, 16'h0000, 0, 0, 0);
    send("sysex", 8'hF7, 16'h0000, 0, 0, 0);
    send("sysex", 8'h3F, 16'h0000, 0, 0, 0);
    send("sysex", 8'h64, 16'h0000, 0, 0, 0);

    // Reset in the middle of a message while a note is held
    send("mid", 8'h90, 16'h0000, 0, 0, 0);
    send("mid", 8'h3F, 16'h0000, 0, 0, 0);
    send("mid", 8'h64, 16'h3F64, 1, 0, 0);
    send("mid", 8'h90, 16'h3F64, 0, 0, 0);
    send("mid", 8'h3F, 16'h3F64, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("mid_async_reset", {data_out, note_on, note_off, error}, {16'h0000, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    send("mid", 8'h64, 16'h0000, 0, 0, 1);

    // Channel handling
`ifdef MIDI_CHANNEL_FILTER_EN
    send("chan", 8'h91, 16'h0000, 0, 0, 0);
    send("chan", 8'h3F, 16'h0000, 0, 0, 0);
    send("chan", 8'h64, 16'h0000, 0, 0, 0);
    send("chan", 8'h90, 16'h0000, 0, 0, 0);
    send("chan", 8'h3F, 16'h0000, 0, 0, 0);
    send("chan", 8'h64, 16'h3F64, 1, 0, 0);
`else
    send("chan", 8'h91, 16'h0000, 0, 0, 0);
    send("chan", 8'h3F, 16'h0000, 0, 0, 0);
    send("chan", 8'h64, 16'h3F64, 1, 0, 0);
    send("chan", 8'h8F, 16'h3F64, 0, 0, 0);
    send("chan", 8'h3F, 16'h3F64, 0, 0, 0);
    send("chan", 8'h00, 16'h0000, 0, 1, 0);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Byte-level MIDI channel-voice parser that sits directly upstream of the synthesizer core.
- Consumes received bytes from the MIDI UART and drives the 16-bit note word the synthesizer decodes: note number in [15:8], velocity in [7:0].
- Monophonic, last-note priority. Word holds while the key is down and returns to 0 on release.
- Also emits single-cycle event strobes for the voice manager.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when channel filtering is compiled in.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- byte_in  input  8  received MIDI byte
- byte_valid  input  1  byte_in is valid this cycle; single-cycle pulse per byte
- data_out  output  16  {note[7:0], velocity[7:0]} of the active note; 16'h0000 when no note is held
- note_on  output  1  1-cycle strobe: data_out was loaded with a new note this cycle
- note_off  output  1  1-cycle strobe: the active note was released this cycle
- error  output  1  1-cycle strobe: data byte received with no valid running status

Behaviour:
- Reset (async, rst_n=0): data_out=0, note_on=0, note_off=0, error=0, state=IDLE, running status cleared, stored note=0. Reset mid-message discards the partial message.
- Byte classes:
  - status: bit7=1, value < F8
  - realtime: F8-FF
  - data: bit7=0
- Realtime bytes are ignored entirely. State, running status and the partial message are untouched, even between the two data bytes.
- States:
  - IDLE: no running status.
  - D1: waiting for the first data byte (note).
  - D2: waiting for the second data byte (velocity).
  - SKIP: ignoring data bytes.
- Status 8n/9n (n = channel): latch status as running status; go to D1.
- Any other channel status (An-En): go to SKIP; clear running status.
- F0-F7: go to SKIP; clear running status. F7 ends a SysEx, and the block stays in SKIP.
- A status byte in any state aborts the partial message; the new status is taken immediately.
- IDLE + data byte: error=1 for one cycle; stay in IDLE.
- SKIP + data byte: ignored, no error.
- D1 + data: latch the note; go to D2.
- D2 + data: the message is complete. Latch velocity, act on it, then return to D1 (running status).
- Message action, evaluated on the cycle after the completing byte (registered outputs):
  - Note On with velocity != 0: data_out={note,vel}; note_on=1. This applies even if a different note is already held (last-note priority).
  - Note Off, or Note On with velocity 0:
    - If note equals data_out[15:8] and data_out != 0: data_out=0; note_off=1.
    - Otherwise: no change, no strobe.
- Note 0 with velocity > 0 is legal: data_out={8'h00,vel}.
- Latency: byte_valid on the last byte at cycle N gives data_out and strobe valid at cycle N+1.
- note_on and note_off are never high in the same cycle.
- Inputs are only sampled when byte_valid=1. byte_valid with no change of state is legal.

Optional Feature:
- Macro: MIDI_CHANNEL_FILTER_EN.
- Defined: only 8n/9n with n==CHANNEL enter D1. Note status on any other channel is treated like other channel statuses: go to SKIP, clear running status.
- Not defined: omni mode. 8x/9x on every channel is accepted; CHANNEL is unused.

Test Plan:
- Basic note: bytes 90,3F,64 → cycle after 64: data_out=16'h3F64, note_on=1 for 1 cycle. Then 80,3F,00 → data_out=0, note_off=1.
- Running status and vel-0 release: 90,3C,40,3C,00 → data_out=3C40, then 0000 with note_off. A further 3E,7F (no status) → data_out=3E7F.
- Last-note priority: 90,3C,40,3E,50,3C,00 → data_out=3E50 after the third pair. The release of 3C produces no change and no note_off. Then 3E,00 → 0000.
- Realtime interleave and abort: 90,F8,3F,FE,64 → data_out=3F64. Then 90,3F,B0,07,64 → no change, no strobes (the CC is skipped).
- Error and SysEx: after reset, 3F → error=1 for one cycle, data_out=0. Then F0,3F,64,F7,3F,64 → no outputs.
- Reset mid-message and channel filter: 90,3F, assert rst_n=0 → all outputs 0. Then 64 alone → error. With MIDI_CHANNEL_FILTER_EN and CHANNEL=0: 91,3F,64 → ignored; 90,3F,64 → 3F64.
